seq_bcd_converter: RTL
======================

Name: seq_bcd_converter

Overview:
- Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Parametrised successor to the fixed 14-bit/4-digit combinational converter; trades latency for area and scales to wide inputs.
- Sits between arithmetic datapaths (counters, accumulators) and display/UART formatting logic.
- Start/busy/done handshake; result held stable until the next conversion completes.

Parameters:
- BIN_W, 14, binary input width in bits (legal range 1..32).
- DIGITS, 4, number of BCD output digits (legal range 1..10).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned binary operand; captured on an accepted start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/overflow update.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0].
- overflow  output  1  set when the operand exceeds 10^DIGITS-1; valid with done and held with bcd_out.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, bcd_out=0, overflow=0; internal shift register, accumulator and counter cleared.
- States:
  - IDLE: if start=1, latch bin_in into the shift register, clear the accumulator and sticky overflow, load count=BIN_W, go to SHIFT; busy=1 from the next cycle.
  - SHIFT: each cycle, apply +3 to every accumulator digit >=5, then shift {accumulator, shift reg} left by 1 with the shift-reg MSB entering accumulator bit 0; decrement count. After the BIN_W-th shift, go to DONE.
  - DONE: register the result into bcd_out/overflow; done=1 for exactly this cycle; busy=0; next state IDLE.
- Latency: start accepted at edge N -> done high in the cycle after edge N+BIN_W+1; bcd_out valid in that same cycle.
- Throughput: a new start is accepted the cycle after done (one idle cycle between conversions); start in SHIFT or DONE is ignored, not queued.
- bin_in is sampled only on acceptance; changes during SHIFT have no effect.
- Overflow: a 1 shifted out of the MSB of digit DIGITS-1 sets the sticky overflow flag. On completion with overflow=1, bcd_out saturates to all digits 4'h9.
- Arithmetic: digit correction is 4-bit, with no carry between digits other than via the shift; digits never exceed 9 after a shift.
- bcd_out and overflow are unchanged outside DONE; busy and done are never high together.
- Reset mid-conversion aborts immediately; no done pulse is issued.
- Zero is a legal operand: result is all-zero digits and overflow=0.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined: at DONE, every leading zero digit above digit 0 is replaced by 4'hF (blank code for the seven-segment decoder). Digit 0 is never blanked, and no blanking applies when overflow=1. Adds no latency.
- Undefined: leading zeros are output as 4'h0; no blanking logic is present.

Test Plan:
- Defaults, bin_in=9999 with a start pulse -> busy for 14 cycles; done one cycle later; bcd_out=16'h9999, overflow=0.
- bin_in=0, then bin_in=1 back-to-back (second start the cycle after done) -> 16'h0000 then 16'h0001; both done pulses seen; second conversion accepted.
- bin_in=12345 -> overflow=1, bcd_out=16'h9999; next conversion of 42 -> overflow=0, bcd_out=16'h0042.
- start re-pulsed with bin_in=77 during SHIFT of a conversion of 500 -> only one done; bcd_out=16'h0500.
- rst_n asserted 5 cycles into the conversion of 8000 -> all outputs 0 asynchronously, no done; a fresh start with 8000 -> 16'h8000.
- BCD_LEADING_ZERO_BLANK_EN defined: 42 -> 16'hFF42; 0 -> 16'hFFF0; 12345 -> 16'h9999 with overflow=1. Undefined: 42 -> 16'h0042.
- Parameter sweep BIN_W=20, DIGITS=7: 1048575 -> 28'h1048575, latency 21 cycles from start to done.

Source files
------------

// File: rtl/seq_bcd_converter_if.sv
// Start/busy/done bus between a requester and seq_bcd_converter.
// The master drives the operand and start; the slave returns status and the packed BCD result.
interface seq_bcd_converter_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/seq_bcd_converter.sv
// Sequential binary to packed BCD (double dabble), one operand bit per clock; optional BCD_LEADING_ZERO_BLANK_EN.
// Latency: start accepted at edge N -> done/bcd_out valid in the cycle after edge N+BIN_W+1.
// No backpressure: start is only sampled in IDLE; starts during SHIFT/DONE are dropped, not queued.
module seq_bcd_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_bcd_converter_if.slave   bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BIN_W-1:0]  sr_q, sr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ACC_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  acc_shifted;
    logic              acc_carry_out;
    logic [BIN_W-1:0]  sr_shifted;
    logic [ACC_W-1:0]  result;

    // Add-3 correction: each digit independently, no inter-digit carry.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_shifted   = {acc_adj[ACC_W-2:0], sr_q[BIN_W-1]};
    assign acc_carry_out = acc_adj[ACC_W-1];
    assign sr_shifted    = sr_q << 1;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead_zero;

    always_comb begin
        result    = acc_q;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead_zero && (acc_q[4*i +: 4] == 4'h0)) begin
                result[4*i +: 4] = 4'hF;
            end else begin
                lead_zero = 1'b0;
            end
        end
        if (sticky_q) begin
            result = {DIGITS{4'h9}};
        end
    end
`else
    always_comb begin
        result = sticky_q ? {DIGITS{4'h9}} : acc_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sr_d     = bus.bin_in;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_W'(BIN_W);
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d    = acc_shifted;
                sr_d     = sr_shifted;
                sticky_d = sticky_q | acc_carry_out;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = result;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule
